// File: rtl/fht_loader.sv
// Input stage for the FHT core: gathers a frame of 4*2^A_BIT samples from a valid/ready stream,
// scatters them over the core's four RAM banks, strobes START and waits for the core to finish.
module fht_loader #(
    parameter int D_BIT   = 16,
    parameter int A_BIT   = 8,
    parameter int BIT_REV = 1
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iVALID,
    input  logic [D_BIT-1:0] iSAMPLE,
    output logic             oREADY,
    output logic [3:0]       oWE,
    output logic [D_BIT-1:0] oDATA,
    output logic [A_BIT-1:0] oADDR_WR,
    output logic             oSTART,
    input  logic             iFHT_RDY,
    input  logic             iCLR_OVF,
    output logic             oOVF,
    output logic             oBUSY,
    output logic [15:0]      oFRAME_CNT
);

    localparam int N_BIT = A_BIT + 2;

    typedef enum logic [1:0] {LOAD, FIRE, ARM, WAIT} state_t;

    state_t             state_q, state_d;
    logic [N_BIT-1:0]   n_q, n_d;
    logic [3:0]         we_q, we_d;
    logic [D_BIT-1:0]   data_q, data_d;
    logic [A_BIT-1:0]   addr_q, addr_d;
    logic               ovf_q, ovf_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               rdy_prev_q, rdy_prev_d;

    logic [N_BIT-1:0]   n_rev;
    logic [N_BIT-1:0]   idx;
    logic               xfer;

    for (genvar gi = 0; gi < N_BIT; gi++) begin : g_rev
        assign n_rev[gi] = n_q[N_BIT-1-gi];
    end

    assign idx = (BIT_REV != 0) ? n_rev : n_q;

    // Ready is gated by the reset input so it reads 0 while the block is held in reset.
    assign oREADY     = (state_q == LOAD) && iRESET;
    assign xfer       = iVALID && oREADY;
    assign oSTART     = (state_q == ARM);
    assign oBUSY      = (state_q == ARM) || (state_q == WAIT);
    assign oWE        = we_q;
    assign oDATA      = data_q;
    assign oADDR_WR   = addr_q;
    assign oOVF       = ovf_q;
    assign oFRAME_CNT = frame_cnt_q;

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        we_d        = 4'b0000;
        data_d      = data_q;
        addr_d      = addr_q;
        frame_cnt_d = frame_cnt_q;
        rdy_prev_d  = iFHT_RDY;

        case (state_q)
            LOAD: begin
                if (xfer) begin
                    we_d   = 4'b0001 << idx[1:0];
                    addr_d = idx[N_BIT-1:2];
                    data_d = iSAMPLE;
                    if (n_q == {N_BIT{1'b1}}) begin
                        n_d     = '0;
                        state_d = FIRE;
                    end else begin
                        n_d = n_q + N_BIT'(1);
                    end
                end
            end
            FIRE: begin
                state_d     = ARM;
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
            ARM: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Core RDY may still be high from the previous frame; only a fresh rise counts.
                if (iFHT_RDY && !rdy_prev_q) begin
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase

        if (iVALID && !oREADY) begin
            ovf_d = 1'b1;
        end else if (iCLR_OVF) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q     <= LOAD;
            n_q         <= '0;
            we_q        <= '0;
            data_q      <= '0;
            addr_q      <= '0;
            ovf_q       <= 1'b0;
            frame_cnt_q <= '0;
            rdy_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            we_q        <= we_d;
            data_q      <= data_d;
            addr_q      <= addr_d;
            ovf_q       <= ovf_d;
            frame_cnt_q <= frame_cnt_d;
            rdy_prev_q  <= rdy_prev_d;
        end
    end

endmodule

// File: tb/tb_fht_loader.sv
// Directed bench for fht_loader: a linear-order and a bit-reversed instance share one stimulus
// stream; every observation is checked against hand-derived values with immediate assertions.
module tb_fht_loader;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [15:0] sample;
    logic        fht_rdy;
    logic        clr_ovf;

    logic        ready0, start0, ovf0, busy0;
    logic [3:0]  we0;
    logic [15:0] data0, fc0;
    logic [7:0]  addr0;

    logic        ready1, start1, ovf1, busy1;
    logic [3:0]  we1;
    logic [15:0] data1, fc1;
    logic [7:0]  addr1;

    int total = 0;
    int bad   = 0;

    fht_loader #(.D_BIT(16), .A_BIT(8), .BIT_REV(0)) u_lin (
        .iCLK(clk), .iRESET(rst_n), .iVALID(valid), .iSAMPLE(sample), .oREADY(ready0),
        .oWE(we0), .oDATA(data0), .oADDR_WR(addr0), .oSTART(start0), .iFHT_RDY(fht_rdy),
        .iCLR_OVF(clr_ovf), .oOVF(ovf0), .oBUSY(busy0), .oFRAME_CNT(fc0)
    );

    fht_loader #(.D_BIT(16), .A_BIT(8), .BIT_REV(1)) u_rev (
        .iCLK(clk), .iRESET(rst_n), .iVALID(valid), .iSAMPLE(sample), .oREADY(ready1),
        .oWE(we1), .oDATA(data1), .oADDR_WR(addr1), .oSTART(start1), .iFHT_RDY(fht_rdy),
        .iCLR_OVF(clr_ovf), .oOVF(ovf1), .oBUSY(busy1), .oFRAME_CNT(fc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] smp(input int k);
        return 16'(k * 37 + 32'h8001);
    endfunction

    function automatic logic [9:0] rev10(input int k);
        logic [9:0] v;
        logic [9:0] r;
        v = 10'(k);
        for (int i = 0; i < 10; i++) r[i] = v[9-i];
        return r;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] b);
        logic [3:0] w;
        w = 4'b0001;
        return w << b;
    endfunction

    initial begin
        int k;
        int cyc;
        int nstart;
        logic [9:0] r;
        logic [9:0] kk;

        rst_n = 1'b0; valid = 1'b0; sample = '0; fht_rdy = 1'b0; clr_ovf = 1'b0;
        step(); step();
        chk("rst_ready0", ready0, 0);
        chk("rst_ready1", ready1, 0);
        chk("rst_we0", we0, 0);
        chk("rst_we1", we1, 0);
        chk("rst_data0", data0, 0);
        chk("rst_addr0", addr0, 0);
        chk("rst_start0", start0, 0);
        chk("rst_busy0", busy0, 0);
        chk("rst_fc0", fc0, 0);
        chk("rst_ovf0", ovf0, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready0", ready0, 1);
        chk("rel_ready1", ready1, 1);

        // Frame 1: continuous stream, core RDY stale-high throughout.
        fht_rdy = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            valid = 1'b1;
            sample = smp(i);
            chk("f1_ready", ready0, 1);
            step();
            kk = 10'(i);
            chk("f1_we_lin", we0, onehot(kk[1:0]));
            chk("f1_addr_lin", addr0, 32'(i / 4));
            chk("f1_data_lin", data0, smp(i));
            r = rev10(i);
            chk("f1_we_rev", we1, onehot(r[1:0]));
            chk("f1_addr_rev", addr1, r[9:2]);
            chk("f1_data_rev", data1, smp(i));
            chk("f1_no_start", start0, 0);
            if (i == 1) begin
                chk("rev_n1_we", we1, 4'b0001);
                chk("rev_n1_addr", addr1, 128);
            end
            if (i == 2) begin
                chk("rev_n2_we", we1, 4'b0001);
                chk("rev_n2_addr", addr1, 64);
            end
            if (i == 1023) begin
                chk("rev_n1023_we", we1, 4'b1000);
                chk("rev_n1023_addr", addr1, 255);
            end
        end
        valid = 1'b0;
        chk("fire_ready", ready0, 0);
        chk("fire_start", start0, 0);
        step();
        chk("arm_start0", start0, 1);
        chk("arm_start1", start1, 1);
        chk("arm_busy", busy0, 1);
        chk("arm_fc", fc0, 1);
        chk("arm_we", we0, 0);
        step();
        chk("wait_start", start0, 0);
        chk("wait_busy", busy0, 1);
        chk("wait_fc", fc0, 1);
        repeat (4) step();
        chk("stale_busy", busy0, 1);
        chk("stale_ready", ready0, 0);

        // Overflow flag while waiting.
        valid = 1'b1;
        step();
        chk("ovf_set", ovf0, 1);
        valid = 1'b0;
        step();
        chk("ovf_sticky", ovf0, 1);
        clr_ovf = 1'b1;
        step();
        chk("ovf_clr", ovf0, 0);
        valid = 1'b1;
        step();
        chk("ovf_set_wins", ovf0, 1);
        chk("ovf_set_wins_rev", ovf1, 1);
        valid = 1'b0; clr_ovf = 1'b0;

        fht_rdy = 1'b0;
        step();
        chk("rdy_low_busy", busy0, 1);
        chk("rdy_low_ready", ready0, 0);
        fht_rdy = 1'b1;
        step();
        chk("rise_ready0", ready0, 1);
        chk("rise_ready1", ready1, 1);
        chk("rise_busy", busy0, 0);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("ovf_clr2", ovf0, 0);
        chk("idle_we", we0, 0);

        // Frame 2: random iVALID gaps.
        k = 0;
        cyc = 0;
        while (k < 1024 && cyc < 5000) begin
            valid = 1'($urandom_range(0, 1));
            sample = smp(k) ^ 16'h5A5A;
            step();
            cyc++;
            if (valid) begin
                kk = 10'(k);
                chk("f2_we", we0, onehot(kk[1:0]));
                chk("f2_addr", addr0, 32'(k / 4));
                chk("f2_data", data0, smp(k) ^ 16'h5A5A);
                k++;
            end else begin
                chk("f2_gap_we", we0, 0);
            end
            chk("f2_no_start", start0, 0);
        end
        chk("f2_count", k, 1024);
        valid = 1'b0;
        nstart = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            nstart += int'(start0);
        end
        chk("f2_start_once", nstart, 1);
        chk("f2_ovf", ovf0, 0);
        chk("f2_fc", fc0, 2);
        fht_rdy = 1'b0;
        step();
        fht_rdy = 1'b1;
        step();
        chk("f2_release", ready0, 1);

        // Reset in the middle of a frame.
        for (int i = 0; i < 300; i++) begin
            valid = 1'b1;
            sample = smp(i + 7);
            step();
        end
        valid = 1'b0;
        chk("pre_rst_we", we0, 4'b1000);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", we0, 0);
        chk("mid_rst_addr", addr0, 0);
        chk("mid_rst_data", data0, 0);
        chk("mid_rst_ready", ready0, 0);
        chk("mid_rst_fc", fc0, 0);
        chk("mid_rst_busy", busy0, 0);
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 1023; i++) begin
            valid = 1'b1;
            sample = smp(i);
            step();
        end
        valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("f3_no_start", start0, 0);
            chk("f3_still_load", ready0, 1);
        end
        valid = 1'b1;
        sample = smp(1023);
        step();
        valid = 1'b0;
        chk("f3_last_we", we0, 4'b1000);
        chk("f3_fire_start", start0, 0);
        step();
        chk("f3_start", start0, 1);
        chk("f3_fc", fc0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
